// File: rtl/seq_pattern_gen.sv
// ----------------------------------------------------------------------------
// seq_pattern_gen
//
// Serial pattern transmitter used as stimulus / loopback source for the 101
// sequence detector. A PAT_W-bit pattern captured on an accepted start is sent
// MSB-first, one bit per clock, repeat_cnt times, with gap_len zero bits
// between consecutive repetitions. The stream can be cut short at any time by
// a synchronous abort.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   transmission request, sampled only while idle
//   abort       in   synchronous abort, honoured in any non-idle state
//   pattern     in   [PAT_W] bits to send, MSB first (captured on start)
//   repeat_cnt  in   [CNT_W] number of repetitions (captured on start)
//   gap_len     in   [GAP_W] zero bits between repetitions (captured on start)
//   X           out  serial data bit (registered)
//   valid       out  X carries a pattern bit (registered)
//   busy        out  transmission in progress, pattern or gap bit (registered)
//   done        out  one-cycle completion pulse (registered)
// ----------------------------------------------------------------------------
module seq_pattern_gen #(
    parameter int unsigned PAT_W = 3,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             X,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned          BIT_W    = $clog2(PAT_W);
    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0]     GAP_ONE  = GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q,   pat_d;     // captured pattern, reload source
    logic [PAT_W-1:0]   sh_q,    sh_d;      // shift register, MSB is the bit on X
    logic [BIT_W-1:0]   bit_q,   bit_d;     // index of the bit currently on X
    logic [CNT_W-1:0]   rep_q,   rep_d;     // repetitions still to send after this one
    logic [GAP_W-1:0]   glen_q,  glen_d;    // captured gap length
    logic [GAP_W-1:0]   gcnt_q,  gcnt_d;    // gap cycles remaining, including current
    logic               x_q,     x_d;
    logic               valid_q, valid_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. Outputs are computed for the state
    // being entered and registered together with it, so X/valid/busy/done
    // line up with the state register and have no input-to-output path.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        glen_d  = glen_q;
        gcnt_d  = gcnt_q;
        x_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d  = pattern;
                    glen_d = gap_len;
                    if (repeat_cnt == '0) begin
                        state_d = S_DONE;
                        rep_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SHIFT;
                        rep_d   = repeat_cnt - 1'b1;
                        sh_d    = pattern;
                        bit_d   = '0;
                        x_d     = pattern[PAT_W-1];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end

            S_SHIFT: begin
                if (bit_q == LAST_BIT) begin
                    if (rep_q == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        rep_d = rep_q - 1'b1;
                        if (glen_q == '0) begin
                            // back-to-back: next repetition's MSB follows at once
                            sh_d    = pat_q;
                            bit_d   = '0;
                            x_d     = pat_q[PAT_W-1];
                            valid_d = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            gcnt_d  = glen_q;
                            busy_d  = 1'b1;
                        end
                    end
                end else begin
                    // the bit below the current MSB becomes the next X
                    sh_d    = sh_q << 1;
                    bit_d   = bit_q + 1'b1;
                    x_d     = sh_q[PAT_W-2];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            S_GAP: begin
                if (gcnt_q == GAP_ONE) begin
                    state_d = S_SHIFT;
                    sh_d    = pat_q;
                    bit_d   = '0;
                    x_d     = pat_q[PAT_W-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                    busy_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort overrides every normal transition outside IDLE
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            x_d     = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State, datapath and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            glen_q  <= '0;
            gcnt_q  <= '0;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            glen_q  <= glen_d;
            gcnt_q  <= gcnt_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign X     = x_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// ----------------------------------------------------------------------------
// tb_seq_pattern_gen
//
// Scoreboard bench for seq_pattern_gen. The driver computes the expected
// per-cycle (X, valid, busy, done) stream of each transmission from the
// pattern/repeat/gap rules and queues it; a monitor on the falling clock edge
// pops one entry for every cycle in which the DUT shows any activity.
// ----------------------------------------------------------------------------
module tb_seq_pattern_gen;

    localparam int PAT_W = 3;
    localparam int CNT_W = 4;
    localparam int GAP_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] repeat_cnt = '0;
    logic [GAP_W-1:0] gap_len = '0;
    logic             X, valid, busy, done;

    typedef struct packed {
        logic x;
        logic v;
        logic b;
        logic d;
    } obs_t;

    obs_t exp_q[$];
    logic vbits[$];
    int   total = 0;
    int   bad = 0;

    seq_pattern_gen #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W),
        .GAP_W(GAP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .X          (X),
        .valid      (valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream for one accepted start: every busy cycle, then done.
    task automatic push_model(input logic [PAT_W-1:0] p, input int r, input int g);
        obs_t e;
        if (r == 0) begin
            e = '{x: 1'b0, v: 1'b0, b: 1'b0, d: 1'b1};
            exp_q.push_back(e);
            return;
        end
        for (int rep = 0; rep < r; rep++) begin
            for (int b = PAT_W - 1; b >= 0; b--) begin
                e = '{x: p[b], v: 1'b1, b: 1'b1, d: 1'b0};
                exp_q.push_back(e);
            end
            if (rep < r - 1) begin
                for (int k = 0; k < g; k++) begin
                    e = '{x: 1'b0, v: 1'b0, b: 1'b1, d: 1'b0};
                    exp_q.push_back(e);
                end
            end
        end
        e = '{x: 1'b0, v: 1'b0, b: 1'b0, d: 1'b1};
        exp_q.push_back(e);
    endtask

    // Full transmission: start, scramble inputs while busy, wait for done.
    task automatic send(input logic [PAT_W-1:0] p, input int r, input int g,
                        input bit hold, input bit with_abort);
        int n;
        int exp_n;
        @(posedge clk); #1;
        pattern    = p;
        repeat_cnt = CNT_W'(r);
        gap_len    = GAP_W'(g);
        start      = 1'b1;
        abort      = with_abort;
        push_model(p, r, g);
        @(posedge clk); #1;
        abort = 1'b0;
        if (!hold) start = 1'b0;
        n = 0;
        while (!done && n < 2000) begin
            pattern    = PAT_W'($urandom);
            repeat_cnt = CNT_W'($urandom);
            gap_len    = GAP_W'($urandom);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        exp_n = (r == 0) ? 0 : r * PAT_W + (r - 1) * g;
        chk("accept_to_done_cycles", n, exp_n);
        @(posedge clk); #1;
        chk("done_single_cycle", done, 1'b0);
        chk("idle_after_done", {X, valid, busy}, 3'b000);
    endtask

    // Monitor: one scoreboard entry per active cycle.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (X || valid || busy || done)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_activity", {X, valid, busy, done}, 4'b0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_x_valid_busy_done", {X, valid, busy, done}, e);
                end
                if (valid) vbits.push_back(X);
            end
        end
    end

    initial begin
        int cnt101;
        int r;
        #12;
        chk("reset_outputs", {X, valid, busy, done}, 4'b0000);
        #5 rst_n = 1'b1;

        // 1: single 101
        send(3'b101, 1, 0, 1'b0, 1'b0);

        // 2: 101 x3 back-to-back, count detector hits on the valid stream
        vbits.delete();
        send(3'b101, 3, 0, 1'b0, 1'b0);
        cnt101 = 0;
        for (int i = 0; i + 2 < vbits.size(); i++)
            if (vbits[i] == 1'b1 && vbits[i+1] == 1'b0 && vbits[i+2] == 1'b1) cnt101++;
        chk("detector_101_hits", cnt101, 3);
        chk("valid_bit_count", vbits.size(), 9);

        // 3: 110 x2 with 2-cycle gap
        send(3'b110, 2, 2, 1'b0, 1'b0);

        // 4: zero repetitions
        send(3'b111, 0, 3, 1'b0, 1'b0);

        // abort together with start in IDLE: start wins
        send(3'b100, 2, 1, 1'b0, 1'b1);

        // 5: abort after the 2nd bit of a 4-repetition transmission
        @(posedge clk); #1;
        pattern = 3'b101; repeat_cnt = 4'd4; gap_len = 3'd1; start = 1'b1;
        push_model(3'b101, 4, 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        chk("idle_after_abort", {X, valid, busy, done}, 4'b0000);
        send(3'b010, 2, 0, 1'b0, 1'b0);

        // 6: async reset in the middle of a gap, then held start
        @(posedge clk); #1;
        pattern = 3'b110; repeat_cnt = 4'd2; gap_len = 3'd3; start = 1'b1;
        push_model(3'b110, 2, 3);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("in_gap_before_reset", {valid, busy}, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {X, valid, busy, done}, 4'b0000);
        exp_q.delete();
        #4 rst_n = 1'b1;
        send(3'b011, 1, 0, 1'b1, 1'b0);
        send(3'b101, 3, 2, 1'b1, 1'b0);

        // randomized transmissions
        for (int t = 0; t < 25; t++) begin
            r = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 5));
            send(PAT_W'($urandom), r, int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
